// File: rtl/stopwatch_bcd_display.sv
// BCD stopwatch with start/stop, clear and lap freeze. It scans a registered snapshot of
// the count onto an 8-digit active-low seven-segment display, with optional leading-zero blanking.
module stopwatch_bcd_display #(
  parameter int unsigned TICK_DIV = 1_000_000,
  parameter int unsigned SCAN_DIV = 200_000,
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [7:0] anode_select,
  output logic [6:0] segs,
  output logic       running,
  output logic       overflow
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W  = 4 * DIGITS;
  localparam int unsigned IDX_W  = 3;

  logic              ss_prev_q, clr_prev_q, lap_prev_q;
  logic              run_q, run_d;
  logic              ovf_q, ovf_d;
  logic              freeze_q, freeze_d;
  logic [TICK_W-1:0] presc_q, presc_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  count_q, count_d, count_inc;
  logic [CNT_W-1:0]  snap_q, snap_d;
  logic [7:0]        anode_q, anode_d;
  logic [6:0]        segs_q, segs_d;

  logic ss_edge, clr_edge, lap_edge, tick, inc_carry;
  logic nonzero_hi, blank;
  logic [3:0] cur_digit;
  logic [6:0] seg_dec;

  assign ss_edge  = start_stop & ~ss_prev_q;
  assign clr_edge = clear & ~clr_prev_q;
  assign lap_edge = lap & ~lap_prev_q;
  assign tick     = run_q && (presc_q == TICK_W'(TICK_DIV - 1));

  // Ripple BCD increment; a carry out of the top digit means the count was all nines
  always_comb begin
    count_inc = count_q;
    inc_carry = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (inc_carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          inc_carry           = 1'b0;
        end
      end
    end
  end

  // Clear wins over tick and lap; start_stop toggles regardless
  always_comb begin
    run_d    = run_q ^ ss_edge;
    ovf_d    = ovf_q;
    freeze_d = freeze_q;
    presc_d  = presc_q;
    count_d  = count_q;
    scan_d   = scan_q;
    idx_d    = idx_q;
    snap_d   = freeze_q ? snap_q : count_q;
    if (clr_edge) begin
      count_d  = '0;
      presc_d  = '0;
      ovf_d    = 1'b0;
      freeze_d = 1'b0;
    end else begin
      if (tick) begin
        presc_d = '0;
        count_d = count_inc;
        if (inc_carry) ovf_d = 1'b1;
      end else if (run_q) begin
        presc_d = presc_q + TICK_W'(1);
      end
      if (lap_edge) freeze_d = ~freeze_q;
    end
    if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_d = '0;
      idx_d  = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end else begin
      scan_d = scan_q + SCAN_W'(1);
    end
  end

  // Digit select, leading-zero detection and segment decode for the scanned slot
  always_comb begin
    cur_digit  = 4'd0;
    nonzero_hi = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_q == IDX_W'(i)) cur_digit = snap_q[4*i +: 4];
      if ((IDX_W'(i) >= idx_q) && (snap_q[4*i +: 4] != 4'd0)) nonzero_hi = 1'b1;
    end
    blank = (BLANK_LZ != 0) && (idx_q != '0) && !nonzero_hi;
    case (cur_digit)
      4'd0:    seg_dec = 7'b1000000;
      4'd1:    seg_dec = 7'b1111001;
      4'd2:    seg_dec = 7'b0100100;
      4'd3:    seg_dec = 7'b0110000;
      4'd4:    seg_dec = 7'b0011001;
      4'd5:    seg_dec = 7'b0010010;
      4'd6:    seg_dec = 7'b0000010;
      4'd7:    seg_dec = 7'b1111000;
      4'd8:    seg_dec = 7'b0000000;
      4'd9:    seg_dec = 7'b0010000;
      default: seg_dec = 7'b1111111;
    endcase
    anode_d = ~(8'(1) << idx_q);
    segs_d  = blank ? 7'b1111111 : seg_dec;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ss_prev_q  <= 1'b1;
      clr_prev_q <= 1'b1;
      lap_prev_q <= 1'b1;
      run_q      <= 1'b0;
      ovf_q      <= 1'b0;
      freeze_q   <= 1'b0;
      presc_q    <= '0;
      scan_q     <= '0;
      idx_q      <= '0;
      count_q    <= '0;
      snap_q     <= '0;
      anode_q    <= 8'hFE;
      segs_q     <= 7'b1000000;
    end else begin
      ss_prev_q  <= start_stop;
      clr_prev_q <= clear;
      lap_prev_q <= lap;
      run_q      <= run_d;
      ovf_q      <= ovf_d;
      freeze_q   <= freeze_d;
      presc_q    <= presc_d;
      scan_q     <= scan_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      snap_q     <= snap_d;
      anode_q    <= anode_d;
      segs_q     <= segs_d;
    end
  end

  assign anode_select = anode_q;
  assign segs         = segs_q;
  assign running      = run_q;
  assign overflow     = ovf_q;

endmodule

// File: doc/stopwatch_bcd_display.md
# stopwatch_bcd_display

Parametrised stopwatch with an integrated multiplexed seven-segment driver. It counts elapsed time in a configurable number of BCD digits at a configurable tick rate. It supports start/stop, clear, lap-freeze and leading-zero blanking. It scans the digits onto the Nexys A7 8-digit display, and its outputs connect directly to the board's anode and segment pins.

## Interface
Parameters:
- TICK_DIV, 1_000_000: clock cycles per count increment (10 ms at 100 MHz); must be ≥ 1.
- SCAN_DIV, 200_000: clock cycles per display digit slot (2 ms at 100 MHz); must be ≥ 1.
- DIGITS, 8: number of active BCD digits, 1..8.
- BLANK_LZ, 1: 1 blanks leading zeros; 0 shows all active digits.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start_stop  in  1  debounced level; each rising edge toggles run state.
- clear  in  1  debounced level; each rising edge zeroes the count.
- lap  in  1  debounced level; each rising edge toggles display freeze.
- anode_select  out  8  active-low one-hot digit enable; bit 0 is the least significant digit.
- segs  out  7  active-low segments {g,f,e,d,c,b,a}.
- running  out  1  high while counting.
- overflow  out  1  sticky; set when the count wraps from all-9s.

## Operation
- Edge detect: each control input has a registered previous value.
  - An edge is `in & ~prev`.
  - All prev registers reset to 1, so a button held through reset does not fire.
- Run state: `running` toggles on a start_stop edge.
- Prescaler: range 0..TICK_DIV-1.
  - Advances only while running; holds while stopped, so a stop followed by a start resumes the partial period.
  - tick = running && prescaler == TICK_DIV-1; the prescaler wraps to 0 on tick.
- Count: DIGITS BCD digits.
  - On tick, digit 0 increments; a digit at 9 becomes 0 and carries into the next digit.
  - All-9s + tick gives all zeros and sets overflow.
- Clear edge:
  - Count, prescaler and overflow go to 0.
  - Lap freeze is released.
  - `running` is unaffected.
- Priority within one cycle: clear beats tick, so the count is 0 after the edge.
  - A start_stop edge in the same cycle still toggles `running`.
  - A lap edge in the same cycle is ignored, because clear releases the freeze.
- Display snapshot: a register that loads the count every cycle unless lap freeze is active. While frozen it holds, and counting continues underneath.
- Scan:
  - The scan prescaler runs 0..SCAN_DIV-1 continuously, independent of running.
  - On its wrap, digit index 0..DIGITS-1 increments, wrapping to 0.
  - anode_select = ~(1 << index). Bits at or above DIGITS are always 1.
- Segment decode (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Blanking: segs = 1111111 for index i when all of the following hold:
  - BLANK_LZ=1
  - i > 0
  - snapshot digits i..DIGITS-1 are all zero.
  - Digit 0 is never blanked.

## Timing
- Reset values after any cycle with reset low:
  - anode_select = 8'hFE, segs = 7'b1000000
  - running = 0, overflow = 0
  - count, snapshot, prescalers, index = 0; lap freeze released.
- Reset mid-run aborts immediately and discards the count.
- Input sampled high at edge k (with prev low): the effect of start_stop or clear is visible after edge k.
- First tick occurs TICK_DIV cycles after the run-enable edge, counting from prescaler 0.
- Count changes at edge k; snapshot follows at edge k+1.
- anode_select and segs are combinational decodes of the registered index and snapshot. They change together, one cycle after the index or snapshot register updates.
- overflow rises in the same cycle the count shows all zeros after a wrap.

## Test plan
- Reset: hold reset low 3 cycles with start_stop high, then release and hold high 20 cycles.
  - Expect anode 8'hFE, segs 1000000, running 0.
  - No toggle occurs from the held button.
- Count and blank (TICK_DIV=4, SCAN_DIV=2, DIGITS=4): pulse start_stop, wait 40 cycles.
  - Expect count 0010.
  - Index 1 shows 1111001, index 0 shows 1000000.
  - Indices 2 and 3 show 1111111; anode bits 7..4 stay 1.
- Pause/resume: stop with prescaler at 2 and wait 50 cycles; expect no change. Restart; expect the next tick 2 cycles later.
- Overflow (TICK_DIV=1, DIGITS=2): run 100 cycles.
  - Expect count 00 and overflow=1, staying high until clear.
  - A clear edge coincident with a tick gives count 0 and overflow 0.
- Lap: pulse lap at count 5, run to count 12.
  - Expect the display to hold 05, with digit 1 blanked.
  - Pulse lap again; expect the display to show 12 one cycle later.
- Clear while running: clear at count 7.
  - Expect count 0 and running still 1.
  - Next tick occurs TICK_DIV cycles later.
